// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment readback monitor: active-low digit
// codes, the blank code, FSM states and the pattern decoder.
package seg7_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    // Bit order is {a,b,c,d,e,f,g}; 0 means the segment is lit.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    typedef struct packed {
        logic               legal;
        logic [DIGIT_W-1:0] digit;
    } seg_dec_t;

    // Blank and every unlisted code decode as not legal.
    function automatic seg_dec_t seg_decode(input logic [SEG_W-1:0] seg);
        seg_dec_t d;
        d.legal = 1'b1;
        d.digit = '0;
        case (seg)
            SEG_0:   d.digit = DIGIT_W'(0);
            SEG_1:   d.digit = DIGIT_W'(1);
            SEG_2:   d.digit = DIGIT_W'(2);
            SEG_3:   d.digit = DIGIT_W'(3);
            SEG_4:   d.digit = DIGIT_W'(4);
            SEG_5:   d.digit = DIGIT_W'(5);
            SEG_6:   d.digit = DIGIT_W'(6);
            SEG_7:   d.digit = DIGIT_W'(7);
            SEG_8:   d.digit = DIGIT_W'(8);
            SEG_9:   d.digit = DIGIT_W'(9);
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Input register and debounce: raises accept_c for the cycle in which the
// registered pattern completes its STABLE_CYCLES-th consecutive sample.
module seg7_stable_filter
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] seg,
    output logic [SEG_W-1:0] seg_q,
    output logic             accept_c
);

    localparam int unsigned RUN_W = CNT_W + 1;
    localparam logic [RUN_W-1:0] STABLE_RUN = RUN_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);

    logic [SEG_W-1:0] prev_q;
    logic [SEG_W-1:0] last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RUN_W-1:0] run_c;

    // Run length of seg_q including the current sample; one bit wider so a
    // saturated counter plus one never wraps back onto STABLE_RUN.
    always_comb begin
        run_c    = RUN_W'(1);
        if (seg_q == prev_q) begin
            run_c = RUN_W'(cnt_q) + RUN_W'(1);
        end
        accept_c = (run_c == STABLE_RUN) && (seg_q != last_q);
    end

    // Reset leaves last_q at blank so a dark display at power-up is silent.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q  <= SEG_BLANK;
            prev_q <= SEG_BLANK;
            last_q <= SEG_BLANK;
            cnt_q  <= '0;
        end else begin
            seg_q  <= seg;
            prev_q <= seg_q;
            if (run_c >= STABLE_RUN) begin
                cnt_q <= STABLE_CNT;
            end else begin
                cnt_q <= run_c[CNT_W-1:0];
            end
            if (accept_c) begin
                last_q <= seg_q;
            end
        end
    end

endmodule

// File: rtl/seg7_to_bcd_monitor.sv
// Seven-segment readback monitor: debounces the active-low segment lines,
// decodes stable patterns to BCD and offers them on a valid/ready handshake.
// Define SEG7_MON_ERRCNT_EN to add the saturating err_count output.
module seg7_to_bcd_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sa,
    input  logic               sb,
    input  logic               sc,
    input  logic               sd,
    input  logic               se,
    input  logic               sf,
    input  logic               sg,
    output logic [DIGIT_W-1:0] bcd,
    output logic               bcd_valid,
    input  logic               bcd_ready,
    output logic               blank,
    output logic               pattern_err,
    output logic               overrun
`ifdef SEG7_MON_ERRCNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    logic [SEG_W-1:0]   seg_q;
    logic               accept_c;
    seg_dec_t           dec_c;
    logic               is_blank_c;

    state_t             state_q;
    state_t             state_d;
    logic [DIGIT_W-1:0] bcd_d;
    logic               blank_d;
    logic               err_d;
    logic               overrun_d;

    seg7_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .seg     ({sa, sb, sc, sd, se, sf, sg}),
        .seg_q   (seg_q),
        .accept_c(accept_c)
    );

    assign dec_c      = seg_decode(seg_q);
    assign is_blank_c = (seg_q == SEG_BLANK);

    // Next state and next output values.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd;
        blank_d   = blank;
        err_d     = 1'b0;
        overrun_d = overrun;

        if (accept_c) begin
            if (is_blank_c) begin
                blank_d = 1'b1;
            end else begin
                blank_d = 1'b0;
                err_d   = !dec_c.legal;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept_c && dec_c.legal) begin
                    bcd_d   = dec_c.digit;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // A same-cycle handshake hands over the old digit, so only an
                // unacknowledged replacement counts as an overrun.
                if (accept_c && dec_c.legal) begin
                    bcd_d = dec_c.digit;
                    if (!bcd_ready) begin
                        overrun_d = 1'b1;
                    end
                end else if (bcd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bcd         <= '0;
            bcd_valid   <= 1'b0;
            blank       <= 1'b0;
            pattern_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd         <= bcd_d;
            bcd_valid   <= (state_d == OFFER);
            blank       <= blank_d;
            pattern_err <= err_d;
            overrun     <= overrun_d;
        end
    end

`ifdef SEG7_MON_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_d && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_to_bcd_monitor.sv
// Bench for seg7_to_bcd_monitor: directed segment patterns, a history-based
// reference model compared every cycle, and hand-computed spot checks.
module tb_seg7_to_bcd_monitor;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'b1111111;
    logic       ready = 1'b0;
    logic [3:0] bcd;
    logic       bcd_valid, blank, pattern_err, overrun;
`ifdef SEG7_MON_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int passed = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    seg7_to_bcd_monitor #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sa         (seg[6]),
        .sb         (seg[5]),
        .sc         (seg[4]),
        .sd         (seg[3]),
        .se         (seg[2]),
        .sf         (seg[1]),
        .sg         (seg[0]),
        .bcd        (bcd),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (ready),
        .blank      (blank),
        .pattern_err(pattern_err),
`ifdef SEG7_MON_ERRCNT_EN
        .err_count  (err_count),
`endif
        .overrun    (overrun)
    );

    // Display codes as written on the datasheet, index = digit.
    logic [6:0] code_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100};

    function automatic int digit_of(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (code_tab[i] == p) return i;
        return -1;
    endfunction

    // Reference model: acceptance from the sample history, outputs one edge later.
    logic [6:0] hist [$];
    logic [6:0] m_last, pend_pat;
    bit         pend;
    int         m_bcd, m_errcnt;
    bit         m_valid, m_blank, m_err, m_over;

    always @(posedge clk) begin
        if (rst) begin
            hist = {};
            hist.push_back(7'b1111111);
            m_last = 7'b1111111; pend = 0; pend_pat = 0;
            m_bcd = 0; m_valid = 0; m_blank = 0; m_err = 0; m_over = 0; m_errcnt = 0;
        end else begin
            int d, run;
            m_err = 0;
            if (m_valid && ready) m_valid = 0;
            if (pend) begin
                d = digit_of(pend_pat);
                if (d >= 0) begin
                    if (m_valid) m_over = 1;
                    m_bcd = d; m_valid = 1; m_blank = 0;
                end else if (pend_pat == 7'b1111111) begin
                    m_blank = 1;
                end else begin
                    m_err = 1; m_blank = 0;
                    if (m_errcnt < 255) m_errcnt++;
                end
            end
            hist.push_back(seg);
            if (hist.size() > 16) void'(hist.pop_front());
            run = 0;
            for (int i = hist.size() - 1; i >= 0 && hist[i] == seg; i--) run++;
            pend = (run == S) && (seg != m_last);
            if (pend) begin
                pend_pat = seg;
                m_last = seg;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            logic [31:0] act, exp;
            act = {20'd0, bcd, bcd_valid, blank, pattern_err, overrun, 4'd0};
            exp = {20'd0, 4'(m_bcd), m_valid, m_blank, m_err, m_over, 4'd0};
`ifdef SEG7_MON_ERRCNT_EN
            act[31:24] = err_count;
            exp[31:24] = 8'(m_errcnt);
`endif
            checks++;
            if (act === exp) passed++;
            else $display("FAIL model t=%0t actual=%h required=%h", $time, act, exp);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    int cnt_v, cnt_e;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
        check("reset_outputs", {bcd, bcd_valid, blank, pattern_err, overrun}, 8'h00);

        // Digit 5 with ready high: offered for exactly one cycle after edge 5.
        ready = 1'b1;
        hold(7'b0100100, 4);
        check("d5_not_yet", bcd_valid, 1'b0);
        hold(7'b0100100, 1);
        check("d5_offered", {bcd, bcd_valid}, {4'd5, 1'b1});
        hold(7'b0100100, 1);
        check("d5_one_cycle", bcd_valid, 1'b0);

        // Segment a toggling every 2 cycles never stabilises.
        cnt_v = 0; cnt_e = 0;
        for (int i = 0; i < 10; i++) begin
            seg = (i % 2 == 0) ? 7'b1100100 : 7'b0100100;
            repeat (2) begin
                @(negedge clk);
                cnt_v += int'(bcd_valid);
                cnt_e += int'(pattern_err);
            end
        end
        check("glitch_no_valid", 32'(cnt_v), 32'd0);
        check("glitch_no_err", 32'(cnt_e), 32'd0);

        // Digit 2 unacknowledged, then digit 3: overrun, 3 offered.
        ready = 1'b0;
        hold(7'b0010010, 6);
        check("d2_offered", {bcd, bcd_valid, overrun}, {4'd2, 1'b1, 1'b0});
        hold(7'b0000110, 6);
        check("d3_overrun", {bcd, bcd_valid, overrun}, {4'd3, 1'b1, 1'b1});
        ready = 1'b1;
        hold(7'b0000110, 1);
        check("d3_single_xfer", bcd_valid, 1'b0);

        // Illegal pattern: exactly one error pulse, nothing offered.
        cnt_v = 0; cnt_e = 0;
        seg = 7'b0110110;
        repeat (8) begin
            @(negedge clk);
            cnt_v += int'(bcd_valid);
            cnt_e += int'(pattern_err);
        end
        check("illegal_one_pulse", 32'(cnt_e), 32'd1);
        check("illegal_no_valid", 32'(cnt_v), 32'd0);

        // Blank, then digit 1 clears blank.
        ready = 1'b0;
        hold(7'b1111111, 6);
        check("blank_set", {blank, bcd_valid}, 2'b10);
        hold(7'b1001111, 6);
        check("blank_clear_d1", {blank, bcd, bcd_valid}, {1'b0, 4'd1, 1'b1});

        // Illegal pattern while offering leaves the digit alone.
        hold(7'b0110110, 6);
        check("err_in_offer", {bcd, bcd_valid}, {4'd1, 1'b1});
        ready = 1'b1;
        hold(7'b0110110, 1);
        ready = 1'b0;

        // Reset mid-offer drops the digit; the same digit is reported again.
        hold(7'b0001111, 6);
        check("d7_offered", {bcd, bcd_valid}, {4'd7, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_offer", {bcd, bcd_valid, blank, pattern_err, overrun}, 8'h00);
        hold(7'b0001111, 4);
        check("d7_again_wait", bcd_valid, 1'b0);
        hold(7'b0001111, 1);
        check("d7_again", {bcd, bcd_valid}, {4'd7, 1'b1});

`ifdef SEG7_MON_ERRCNT_EN
        ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            hold(7'b0110110, 5);
            hold(code_tab[i % 10], 5);
        end
        check("err_count_sat", 32'(err_count), 32'd255);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
